hazard_sched: RTL
=================

HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max consecutive memory-wait cycles before the error state (legal range 2..255).
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rsD, rtD  input  5 each  source registers of the instruction in decode.
REQ-006 branchD, jumpD, pcSrcD  input  1 each  branch in D; jump in D; branch resolved taken in D.
REQ-007 regWriteE, memToRegE  input  1 each; writeRegE  input  5  destination and control of the instruction in execute.
REQ-008 memToRegM  input  1; writeRegM  input  5  load in memory stage and its destination.
REQ-009 dmemReqM, dmemReadyM  input  1 each  data-memory access in M; memory ready/ack.
REQ-010 errClr, cntClr  input  1 each  clear timeout error; clear stall counter.
REQ-011 stallF, stallD  output  1 each  hold PC / hold F-to-D register (drives that register's enable, high = hold).
REQ-012 stallE, stallM  output  1 each  hold D-to-E / E-to-M registers.
REQ-013 flushD, flushE  output  1 each  clear F-to-D / D-to-E registers.
REQ-014 timeoutErr  output  1  sticky memory-timeout flag.
REQ-015 stallCnt  output  CNT_W  saturating count of cycles with stallF high.

Function
REQ-016 States SHALL be RUN, WAIT and ERR, held in registers; waitCnt SHALL be an 8-bit register.
REQ-017 Register 0 SHALL never cause a hazard: every rs/rt match term SHALL require a nonzero source register.
REQ-018 lwStall = memToRegE & (rsD==rtE_dest | rtD==rtE_dest), where the load destination is writeRegE.
REQ-019 brStall = branchD & ((regWriteE & writeRegE matches rsD or rtD) | (memToRegM & writeRegM matches rsD or rtD)).
REQ-020 memStall = (state==RUN | state==WAIT) & dmemReqM & ~dmemReadyM.
REQ-021 Priority, highest first: ERR, memStall, lwStall|brStall, redirect.
REQ-022 ERR or memStall SHALL drive stallF=stallD=stallE=stallM=1 and flushD=flushE=0.
REQ-023 Otherwise, lwStall|brStall SHALL drive stallF=stallD=1, flushE=1, stallE=stallM=0, flushD=0.
REQ-024 Otherwise, (pcSrcD|jumpD) SHALL drive flushD=1; all other outputs 0.
REQ-025 Otherwise, all stall and flush outputs SHALL be 0.
REQ-026 All stall/flush outputs SHALL be combinational from current inputs and state; no added latency.
REQ-027 RUN->WAIT when memStall; waitCnt loads 1.
REQ-028 WAIT->RUN when dmemReadyM | ~dmemReqM; waitCnt resets to 0.
REQ-029 WAIT, still stalled, with waitCnt==MEM_TIMEOUT-1 -> ERR with timeoutErr set; else waitCnt increments.
REQ-030 ERR->RUN only on errClr; timeoutErr SHALL clear on the same edge.
REQ-031 errClr in RUN or WAIT SHALL have no effect.
REQ-032 stallCnt SHALL increment on every edge where stallF=1 and saturate at all-ones.
REQ-033 cntClr SHALL zero stallCnt and take priority over an increment in the same cycle.

Reset
REQ-034 rst low SHALL immediately force state=RUN, waitCnt=0, timeoutErr=0, stallCnt=0, independent of clk.
REQ-035 Reset asserted mid-WAIT or in ERR SHALL abandon the wait; after release, outputs follow REQ-020..025 from RUN.
REQ-036 During reset, stall/flush outputs SHALL reflect combinational hazards from RUN; dmemReqM is expected low.

Verification
REQ-037 Load-use: memToRegE=1, writeRegE=5, rsD=5, one cycle -> stallF=stallD=flushE=1 that cycle, stallCnt +1; with rsD=0 and writeRegE=0 -> no stall.
REQ-038 Branch: branchD=1, regWriteE=1, writeRegE=rtD=7 -> stall; next cycle hazard gone with pcSrcD=1 -> flushD=1 only.
REQ-039 Redirect suppressed: jumpD=1 together with lwStall -> flushD=0, flushE=1.
REQ-040 Mem wait: dmemReqM=1, dmemReadyM low 3 cycles then high -> all four stalls high 3 cycles, state returns to RUN, timeoutErr=0, stallCnt +3.
REQ-041 Timeout: MEM_TIMEOUT=4, dmemReadyM held low -> ERR entered on 4th stalled edge, timeoutErr=1, stalls stay high; errClr pulse -> RUN, timeoutErr=0.
REQ-042 Saturation/clear: CNT_W=4, stall 20 cycles -> stallCnt=15; cntClr together with stall -> 0; rst low mid-WAIT -> all state zero asynchronously.

Source files
------------

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use / branch-operand stalls, redirect flushes,
// and a data-memory wait tracker with a sticky timeout error and a stall counter.
module hazard_sched #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcSrcD,
    input  logic             regWriteE,
    input  logic             memToRegE,
    input  logic [4:0]       writeRegE,
    input  logic             memToRegM,
    input  logic [4:0]       writeRegM,
    input  logic             dmemReqM,
    input  logic             dmemReadyM,
    input  logic             errClr,
    input  logic             cntClr,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             timeoutErr,
    output logic [CNT_W-1:0] stallCnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_timeout_err;
    logic             w_timeout_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs_nz;
    logic w_rt_nz;
    logic w_lw_stall;
    logic w_br_stall;
    logic w_mem_stall;
    logic w_in_err;

    // Register 0 is hardwired to zero, so it can never carry a real dependency.
    assign w_rs_nz = (rsD != 5'd0);
    assign w_rt_nz = (rtD != 5'd0);

    assign w_lw_stall = memToRegE &
                        ((w_rs_nz & (rsD == writeRegE)) | (w_rt_nz & (rtD == writeRegE)));

    assign w_br_stall = branchD &
                        ((regWriteE & ((w_rs_nz & (rsD == writeRegE)) |
                                       (w_rt_nz & (rtD == writeRegE)))) |
                         (memToRegM & ((w_rs_nz & (rsD == writeRegM)) |
                                       (w_rt_nz & (rtD == writeRegM)))));

    assign w_in_err    = (r_state == S_ERR);
    assign w_mem_stall = ~w_in_err & dmemReqM & ~dmemReadyM;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (w_in_err || w_mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (w_lw_stall || w_br_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (pcSrcD || jumpD) begin
            flushD = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_timeout_err_nxt = r_timeout_err;
        unique case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                if (dmemReadyM || !dmemReqM) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_nxt       = S_ERR;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_ERR: begin
                if (errClr) begin
                    w_state_nxt       = S_RUN;
                    w_wait_cnt_nxt    = 8'd0;
                    w_timeout_err_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (cntClr) begin
            r_stall_cnt <= '0;
        end else if (stallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign timeoutErr = r_timeout_err;
    assign stallCnt   = r_stall_cnt;

endmodule
